// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the load/store unit.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  // Load width/sign encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store width encodings
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } lsu_state_t;

  // Access context held for the duration of a bus transaction
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_ctx_t;

  // Byte enables for an access of the given size (funct3[1:0]) at byte offset off
  function automatic logic [LANES-1:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [LANES-1:0] be;
    be = '0;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, access legality,
// and load-result extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [LANES-1:0]      be_c,
  output logic [DATA_WIDTH-1:0] wdata_lanes_c,
  output logic                  bad_c,
  input  logic [2:0]            rd_funct3,
  input  logic [1:0]            rd_off,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] load_ext_c
);

  logic                  illegal;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] shifted;

  // Request side: legality, lane enables and replicated store data
  always_comb begin
    illegal       = 1'b0;
    misaligned    = 1'b0;
    wdata_lanes_c = wdata;
    if (is_store) begin
      illegal = (funct3 > SW);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    bad_c = illegal | misaligned;
    be_c  = lane_be(funct3[1:0], off);
    case (funct3[1:0])
      2'b00:   wdata_lanes_c = {(DATA_WIDTH/8){wdata[7:0]}};
      2'b01:   wdata_lanes_c = {(DATA_WIDTH/16){wdata[15:0]}};
      default: wdata_lanes_c = wdata;
    endcase
  end

  // Response side: right-align the addressed lanes, then extend
  always_comb begin
    shifted = rdata >> {rd_off, 3'b000};
    case (rd_funct3)
      LB:      load_ext_c = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      LH:      load_ext_c = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      LBU:     load_ext_c = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      LHU:     load_ext_c = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns single-cycle ALU/register-file memory requests into
// handshaked bus transactions, stalling the core until completion, fault or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  fault,
  output logic                  timeout,
  load_store_unit_if.master     bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  lsu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  lsu_ctx_t              ctx_q, ctx_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANES-1:0]      be_q, be_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  lv_q, lv_d;
  logic                  to_q, to_d;
  logic [DATA_WIDTH-1:0] ld_q, ld_d;

  logic [LANES-1:0]      be_c;
  logic [DATA_WIDTH-1:0] wdata_lanes_c;
  logic                  bad_c;
  logic [DATA_WIDTH-1:0] load_ext_c;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .is_store      (is_store),
    .funct3        (funct3),
    .off           (addr[1:0]),
    .wdata         (wdata),
    .be_c          (be_c),
    .wdata_lanes_c (wdata_lanes_c),
    .bad_c         (bad_c),
    .rd_funct3     (ctx_q.funct3),
    .rd_off        (ctx_q.off),
    .rdata         (bus.bus_rdata),
    .load_ext_c    (load_ext_c)
  );

  // Next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctx_d   = ctx_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    lv_d    = 1'b0;
    to_d    = 1'b0;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && !bad_c) begin
          state_d = BUS;
          cnt_d   = '0;
          ctx_d   = '{is_store: is_store, funct3: funct3, off: addr[1:0]};
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          be_d    = be_c;
          wd_d    = wdata_lanes_c;
        end
      end
      BUS: begin
        if (bus.bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!ctx_q.is_store) begin
            lv_d = 1'b1;
            ld_d = load_ext_c;
          end
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // Abort: a load must not leave stale data looking like a result
          state_d = DONE;
          req_d   = 1'b0;
          to_d    = 1'b1;
          if (!ctx_q.is_store) begin
            ld_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctx_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      lv_q    <= 1'b0;
      to_q    <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      lv_q    <= lv_d;
      to_q    <= to_d;
      ld_q    <= ld_d;
    end
  end

  // Stall and fault must react in the request cycle itself, so they are decoded from state
  assign stall = rst && ((state_q == BUS) || ((state_q == IDLE) && mem_valid && !bad_c));
  assign fault = rst && (state_q == IDLE) && mem_valid && bad_c;

  assign load_data  = ld_q;
  assign load_valid = lv_q;
  assign timeout    = to_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboarded accesses, faults, timeouts, reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned TO = 4;

  typedef struct {
    logic        lv;
    logic        to;
    logic [31:0] ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];
  logic [31:0] model_ld = 32'h0;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  load_store_unit #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .timeout    (timeout),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    mem_valid = 1'b1;
    is_store = 1'b0;
    funct3 = LW;
    addr = 32'h0;
    wdata = 32'h0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;
    #3;
    vectors++;
    if ({stall, fault, load_valid, timeout, bus_if.bus_req, bus_if.bus_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset ctrl: got %b want 000000", {stall, fault, load_valid, timeout, bus_if.bus_req, bus_if.bus_we});
    end
    vectors++;
    if ({load_data, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata} !== 100'h0) begin
      miscompares++;
      $display("FAIL reset data: ld=%h addr=%h be=%b wd=%h want all 0", load_data, bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata);
    end
    repeat (2) @(posedge clk);
    #1 mem_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One complete access; ack_at = BUS cycle carrying the ack, 0 = never
  task automatic access(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    int          nbus;
    exp_t        e;
    logic [1:0]  off;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] ext;
    logic [7:0]  b;
    logic [15:0] h;
    bit          acked;
    off = a[1:0];
    acked = (ack_at >= 1) && (ack_at <= int'(TO));
    nbus = acked ? ack_at : int'(TO);
    ebe = 4'b0000;
    case (f3[1:0])
      2'b00:   begin ebe[off] = 1'b1; ewd = {4{wd[7:0]}}; end
      2'b01:   begin ebe[off] = 1'b1; ebe[off + 1] = 1'b1; ewd = {2{wd[15:0]}}; end
      default: begin ebe = 4'b1111; ewd = wd; end
    endcase
    b = rd[8*off +: 8];
    h = rd[8*off +: 16];
    case (f3)
      3'b000:  ext = {{24{b[7]}}, b};
      3'b001:  ext = {{16{h[15]}}, h};
      3'b100:  ext = {24'h0, b};
      3'b101:  ext = {16'h0, h};
      default: ext = rd;
    endcase
    if (acked) begin
      if (!st) model_ld = ext;
      e = '{lv: !st, to: 1'b0, ld: model_ld};
    end else begin
      if (!st) model_ld = 32'h0;
      e = '{lv: 1'b0, to: 1'b1, ld: model_ld};
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    mem_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    vectors++;
    if ({stall, fault, bus_if.bus_req, load_valid, timeout} !== 5'b10000) begin
      miscompares++;
      $display("FAIL %s accept stall/fault/req/lv/to: got %b want 10000", name, {stall, fault, bus_if.bus_req, load_valid, timeout});
    end
    for (int n = 1; n <= nbus; n++) begin
      @(posedge clk);
      #1;
      bus_if.bus_ack = (n == ack_at);
      bus_if.bus_rdata = (n == ack_at) ? rd : $urandom;
      @(negedge clk);
      vectors++;
      if ({bus_if.bus_req, stall} !== 2'b11) begin
        miscompares++;
        $display("FAIL %s bus cycle %0d req/stall: got %b want 11", name, n, {bus_if.bus_req, stall});
      end
      if (n == 1) begin
        vectors++;
        if (bus_if.bus_addr !== {a[31:2], 2'b00} || bus_if.bus_be !== ebe || bus_if.bus_we !== st) begin
          miscompares++;
          $display("FAIL %s bus addr/be/we: got %h/%b/%b want %h/%b/%b", name, bus_if.bus_addr, bus_if.bus_be,
                   bus_if.bus_we, {a[31:2], 2'b00}, ebe, st);
        end
        if (st) begin
          vectors++;
          if (bus_if.bus_wdata !== ewd) begin
            miscompares++;
            $display("FAIL %s bus_wdata: got %h want %h", name, bus_if.bus_wdata, ewd);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    vectors++;
    if ({stall, bus_if.bus_req, load_valid, timeout} !== {2'b00, e.lv, e.to}) begin
      miscompares++;
      $display("FAIL %s done stall/req/lv/to: got %b want %b", name, {stall, bus_if.bus_req, load_valid, timeout},
               {2'b00, e.lv, e.to});
    end
    vectors++;
    if (load_data !== e.ld) begin
      miscompares++;
      $display("FAIL %s load_data: got %h want %h", name, load_data, e.ld);
    end
  endtask

  task automatic test_fault(input string name, input logic st, input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk);
    #1;
    mem_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = 32'hCAFEF00D;
    @(negedge clk);
    vectors++;
    if ({fault, stall, bus_if.bus_req} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s fault/stall/req: got %b want 100", name, {fault, stall, bus_if.bus_req});
    end
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fault, stall, bus_if.bus_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s after fault/stall/req: got %b want 000", name, {fault, stall, bus_if.bus_req});
    end
  endtask

  task automatic test_loads();
    access("lb", 1'b0, LB, 32'h0000_2001, 32'h0, 32'h1234_F678, 1);
    access("lbu", 1'b0, LBU, 32'h0000_2001, 32'h0, 32'h1234_F678, 1);
    access("lh", 1'b0, LH, 32'h0000_2002, 32'h0, 32'h8001_0000, 1);
    access("lhu", 1'b0, LHU, 32'h0000_2002, 32'h0, 32'h8001_0000, 1);
    access("lb_off3", 1'b0, LB, 32'h0000_2003, 32'h0, 32'h7F00_0000, 2);
  endtask

  task automatic test_stores();
    access("sb", 1'b1, SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 3);
    access("sh_hi", 1'b1, SH, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1);
    access("sw", 1'b1, SW, 32'h0000_1004, 32'h0BAD_F00D, 32'h0, 2);
  endtask

  task automatic test_faults();
    test_fault("lw_misaligned", 1'b0, LW, 32'h0000_2002);
    test_fault("load_f3_3", 1'b0, 3'b011, 32'h0000_2000);
    test_fault("sh_misaligned", 1'b1, SH, 32'h0000_2001);
    test_fault("store_f3_4", 1'b1, 3'b100, 32'h0000_2000);
  endtask

  task automatic test_timeout();
    access("lw_ack_at_limit", 1'b0, LW, 32'h0000_5000, 32'h0, 32'h0123_4567, 4);
    access("sw_timeout", 1'b1, SW, 32'h0000_5004, 32'h5555_AAAA, 32'h0, 0);
    access("lw_timeout", 1'b0, LW, 32'h0000_5008, 32'h0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    access("b2b_sw", 1'b1, SW, 32'h0000_4000, 32'hA5A5_5A5A, 32'h0, 1);
    access("b2b_lw", 1'b0, LW, 32'h0000_4004, 32'h0, 32'h89AB_CDEF, 1);
    access("b2b_lhu", 1'b0, LHU, 32'h0000_4000, 32'h0, 32'hFFFE_0001, 1);
  endtask

  task automatic test_reset_mid_bus();
    @(posedge clk);
    #1;
    mem_valid = 1'b1; is_store = 1'b0; funct3 = LW; addr = 32'h0000_2000;
    bus_if.bus_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (bus_if.bus_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid pre req: got %b want 1", bus_if.bus_req);
    end
    #2 rst = 1'b0;
    #1;
    model_ld = 32'h0;
    vectors++;
    if ({bus_if.bus_req, stall, load_valid, timeout, fault} !== 5'b0 || load_data !== model_ld) begin
      miscompares++;
      $display("FAIL rst_mid req/stall/lv/to/fault=%b ld=%h want 00000 ld=%h",
               {bus_if.bus_req, stall, load_valid, timeout, fault}, load_data, model_ld);
    end
    mem_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    access("lw_after_reset", 1'b0, LW, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1);
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid_bus();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d entries want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
